serial_mag_cmp: RTL and testbench

//  - Bit-serial WIDTH-bit magnitude comparator. It is the ALU compare stage directly downstream of eq1.
//  - Latches operands a/b on start, then walks them MSB-first, one bit per clock.
//  - Each bit pair goes through one eq1 instance; its eq output drives all decisions.
//  - Reports eq/gt/lt with a start/busy/done handshake. Results hold for the Basys 3 LEDs/7-seg.

---
 rtl/serial_mag_cmp_pkg.sv | 22 ++
 rtl/eq1.sv | 22 ++
 rtl/serial_mag_cmp.sv | 161 ++++++++++++++++
 tb/tb_serial_mag_cmp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_cmp_pkg
// Description : Shared state encoding and counter sizing for the bit-serial
//               magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_mag_cmp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_mag_cmp_pkg
`default_nettype wire

// File: rtl/eq1.sv
`default_nettype none
// ============================================================================
// Module      : eq1
// Description : Single-bit equality cell; eq is high when i0 and i1 match.
// Revision    : 1.0 - initial release
// ============================================================================
module eq1 (
    input  logic i0,
    input  logic i1,
    output logic eq
);

    logic w_p0;
    logic w_p1;

    // Both-zero and both-one product terms.
    assign w_p0 = ~i0 & ~i1;
    assign w_p1 =  i0 &  i1;
    assign eq   = w_p0 | w_p1;

endmodule : eq1
`default_nettype wire

// File: rtl/serial_mag_cmp.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_cmp
// Description : Bit-serial WIDTH-bit unsigned magnitude comparator. Operands
//               are latched on start and walked MSB-first through one eq1
//               cell; eq/gt/lt are registered and held until the next start.
//               Optional build macro SERIAL_MAG_CMP_EARLY_EXIT_EN ends the
//               walk on the first mismatching bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_q,     w_a_d;
    logic [WIDTH-1:0]   r_b_q,     w_b_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic               r_mism_q,  w_mism_d;
    logic               r_busy_q,  w_busy_d;
    logic               r_done_q,  w_done_d;
    logic               r_eq_q,    w_eq_d;
    logic               r_gt_q,    w_gt_d;
    logic               r_lt_q,    w_lt_d;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_bit_eq;
    logic               w_accept;
    logic               w_first_mism;
    logic               w_last_bit;
    logic               w_exit;

    assign w_bit_a = r_a_q[r_cnt_q];
    assign w_bit_b = r_b_q[r_cnt_q];

    eq1 u_eq1 (
        .i0 (w_bit_a),
        .i1 (w_bit_b),
        .eq (w_bit_eq)
    );

    // Next-state and next-output logic for the compare sequencer.
    always_comb begin
        w_state_d    = r_state_q;
        w_a_d        = r_a_q;
        w_b_d        = r_b_q;
        w_cnt_d      = r_cnt_q;
        w_mism_d     = r_mism_q;
        w_busy_d     = r_busy_q;
        w_done_d     = 1'b0;
        w_eq_d       = r_eq_q;
        w_gt_d       = r_gt_q;
        w_lt_d       = r_lt_q;
        w_accept     = start && ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE));
        w_first_mism = 1'b0;
        w_last_bit   = (r_cnt_q == CNT_ZERO);
        w_exit       = 1'b0;

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_cnt_d   = CNT_LAST;
                    w_mism_d  = 1'b0;
                    w_eq_d    = 1'b0;
                    w_gt_d    = 1'b0;
                    w_lt_d    = 1'b0;
                    w_busy_d  = 1'b1;
                    w_state_d = ST_SHIFT;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // Only the most significant differing bit decides gt/lt.
                w_first_mism = !w_bit_eq && !r_mism_q;
                if (w_first_mism) begin
                    w_mism_d = 1'b1;
                    w_gt_d   =  w_bit_a;
                    w_lt_d   = ~w_bit_a;
                end
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
                w_exit = w_last_bit || w_first_mism;
`else
                w_exit = w_last_bit;
`endif
                if (w_exit) begin
                    if (w_last_bit && !r_mism_q && w_bit_eq) begin
                        w_eq_d = 1'b1;
                    end
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - CNT_ONE;
                end
            end

            default: begin
                w_busy_d  = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset discards any compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_cnt_q   <= '0;
            r_mism_q  <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_eq_q    <= 1'b0;
            r_gt_q    <= 1'b0;
            r_lt_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_cnt_q   <= w_cnt_d;
            r_mism_q  <= w_mism_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_eq_q    <= w_eq_d;
            r_gt_q    <= w_gt_d;
            r_lt_q    <= w_lt_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign eq   = r_eq_q;
    assign gt   = r_gt_q;
    assign lt   = r_lt_q;

endmodule : serial_mag_cmp
`default_nettype wire

// File: tb/tb_serial_mag_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mag_cmp
// Description : Self-checking bench for serial_mag_cmp (WIDTH=8). Expected
//               results and done latency come from plain unsigned arithmetic
//               on the operands. Follows SERIAL_MAG_CMP_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_cmp;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle (relative to the accepting edge = cycle 0) in which done is high.
    function automatic int model_done_cycle(input logic [W-1:0] x, input logic [W-1:0] y);
        int lead_equal;
        lead_equal = W;
        for (int i = W - 1; i >= 0; i--) begin
            if ((x >> i) != (y >> i)) begin
                lead_equal = W - 1 - i;
                break;
            end
        end
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        if (lead_equal < W) return lead_equal + 2;
`endif
        return W + 1;
    endfunction

    // Present operands with start for one edge; returns sampling in cycle 1.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cyc   = 1;
    endtask

    // Step cycles until done is seen (bounded); counts busy cycles observed.
    task automatic wait_done(output int dcyc, output int nbusy);
        dcyc  = -1;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input int dcyc, input int nbusy, input int busy_from);
        int dexp;
        dexp = model_done_cycle(x, y);
        check({tag, "_done_cycle"}, dcyc, dexp);
        check({tag, "_busy_cycles"}, nbusy, dexp - busy_from);
        check({tag, "_eq"}, {31'd0, eq}, {31'd0, x == y});
        check({tag, "_gt"}, {31'd0, gt}, {31'd0, x > y});
        check({tag, "_lt"}, {31'd0, lt}, {31'd0, x < y});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d;
        int nb;
        int bad;
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset values.
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands, result held afterwards.
        launch(8'hA5, 8'hA5);
        wait_done(d, nb);
        check_result("a5_a5", 8'hA5, 8'hA5, d, nb, 1);
        bad = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!(eq === 1'b1 && gt === 1'b0 && lt === 1'b0 && done === 1'b0 && busy === 1'b0))
                bad++;
        end
        check("a5_hold_to_cycle20", bad, 0);

        // MSB mismatch, LSB-only mismatch.
        launch(8'h80, 8'h7F);
        wait_done(d, nb);
        check_result("80_7f", 8'h80, 8'h7F, d, nb, 1);
        launch(8'h12, 8'h13);
        wait_done(d, nb);
        check_result("12_13", 8'h12, 8'h13, d, nb, 1);

        // Start while busy is ignored.
        launch(8'h01, 8'h02);
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk); cyc++;
        start = 1'b0;
        wait_done(d, nb);
        check_result("ignored_start", 8'h01, 8'h02, d, nb, 4);

        // Reset in the middle of a compare.
        launch(8'h5A, 8'h5B);
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        @(negedge clk);
        check("midrst_outputs_held", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst_n = 1'b1;
        launch(8'h00, 8'h00);
        wait_done(d, nb);
        check_result("after_rst_00", 8'h00, 8'h00, d, nb, 1);

        // Start held high across the DONE cycle; operand changes while busy ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h7F;
        @(negedge clk);
        cyc = 1;
        a   = 8'h00;
        b   = 8'hFF;
        wait_done(d, nb);
        check_result("held_first", 8'h80, 8'h7F, d, nb, 1);
        a = 8'h33;
        b = 8'h44;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("held_busy_next", {31'd0, busy}, 32'd1);
        check("held_result_cleared", {29'd0, done, eq, gt | lt}, 32'd0);
        wait_done(d, nb);
        check_result("held_second", 8'h33, 8'h44, d, nb, 1);

        // Randomized operands: equal, single-bit difference, or independent.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            x    = W'($urandom);
            if (mode == 0)      y = x;
            else if (mode == 1) y = x ^ (W'(1) << $urandom_range(0, W - 1));
            else                y = W'($urandom);
            launch(x, y);
            wait_done(d, nb);
            check_result($sformatf("rand%0d", n), x, y, d, nb, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_mag_cmp
`default_nettype wire
